// File: rtl/if_alu_seq_if.sv
// if_alu_seq_if: control, operand and result bus between the panel controller and the external ALU core.
interface if_alu_seq_if;
    logic        alu_x, alu_y, alu_z, alu_u, alu_v, alu_als;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_carry, alu_overflow;
    modport master(output alu_x, alu_y, alu_z, alu_u, alu_v, alu_als, alu_a, alu_b,
                   input alu_result, alu_carry, alu_overflow);
    modport slave(input alu_x, alu_y, alu_z, alu_u, alu_v, alu_als, alu_a, alu_b,
                  output alu_result, alu_carry, alu_overflow);
endinterface

// File: rtl/if_alu_seq.sv
// if_alu_seq: debounced key-driven operand entry, op stepping and registered execute for an external ALU.
// Define IF_ALU_SEQ_CHAIN_EN to let EXEC in S_SHOW feed the result back as operand A.
module if_alu_seq #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          key_n_i,
    input  logic [17:0]         sw_i,
    if_alu_seq_if.master        alu,
    output logic [17:0]         ledr_o,
    output logic [7:0]          ledg_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [39:0] CTL = {5'b10001, 5'b00001, 5'b00100, 5'b00000,
                                   5'b11001, 5'b11011, 5'b01011, 5'b01001};
    typedef enum logic [2:0] {S_A, S_B, S_RDY, S_EXEC, S_SHOW} state_t;

    logic [2:0]       s1_q, s2_q, deb_q, prev_q, arm_q, ev;
    logic [CW-1:0]    cnt_q [3];
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, op_val;
    logic [2:0]       op_q, op_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, vld_q, vld_d;
    logic             ld, st, ex;
    logic [1:0]       code;
    logic             unused_bits;

    // Synchronisers start "pressed" so a key held through reset must be seen released before it can arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '1;
            arm_q  <= '0;
        end else begin
            s1_q   <= key_n_i;
            s2_q   <= s1_q;
            prev_q <= deb_q;
            arm_q  <= arm_q | s2_q;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_deb
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[k] <= '0;
                deb_q[k] <= 1'b1;
            end else if (s2_q[k] == deb_q[k]) begin
                cnt_q[k] <= '0;
            end else if (cnt_q[k] == CW'(DEB_CYCLES - 1)) begin
                cnt_q[k] <= '0;
                deb_q[k] <= s2_q[k];
            end else begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    assign ev     = arm_q & prev_q & ~deb_q;
    assign ld     = ev[0];
    assign st     = ev[1];
    assign ex     = ev[2];
    assign op_val = ~sw_i[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        vld_d   = vld_q;
        op_d    = op_q + 3'(st);
        case (state_q)
            S_A: if (ld) begin
                a_d     = op_val;
                state_d = S_B;
            end
            S_B: if (ld) begin
                b_d     = op_val;
                state_d = S_RDY;
            end
            S_RDY: if (ld) begin
                a_d     = op_val;
                state_d = S_B;
            end else if (ex) begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu.alu_result[WIDTH-1:0];
                c_d     = alu.alu_carry;
                v_d     = alu.alu_overflow;
                z_d     = alu.alu_result[WIDTH-1:0] == '0;
                vld_d   = 1'b1;
                state_d = S_SHOW;
            end
            S_SHOW: if (ld) begin
                a_d     = op_val;
                vld_d   = 1'b0;
                state_d = S_B;
            end
`ifdef IF_ALU_SEQ_CHAIN_EN
            else if (ex) begin
                a_d     = res_q;
                state_d = S_EXEC;
            end
`endif
            default: state_d = S_A;
        endcase
    end

    assign {alu.alu_x, alu.alu_y, alu.alu_z, alu.alu_u, alu.alu_v} = CTL[5*op_q +: 5];
    assign alu.alu_als = ~sw_i[17];
    assign alu.alu_a   = (op_q == 3'd7) ? 16'h0000 : 16'(a_q);
    assign alu.alu_b   = 16'(b_q);

    assign code   = (state_q == S_A) ? 2'd0 : (state_q == S_B) ? 2'd1 : (state_q == S_RDY) ? 2'd2 : 2'd3;
    assign ledr_o = {code, (state_q == S_A || state_q == S_B) ? 16'(op_val) :
                           (state_q == S_RDY) ? 16'(b_q) : 16'(res_q)};
    assign ledg_o = {state_q == S_EXEC, vld_q, z_q, v_q, c_q, op_q};

    assign unused_bits = ^{sw_i, alu.alu_result};
endmodule

// File: tb/tb_if_alu_seq.sv
// tb_if_alu_seq: directed bench for if_alu_seq with a behavioural 8-bit ALU model on the bus.
module tb_if_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  key_n;
    logic [17:0] sw;
    logic [17:0] ledr;
    logic [7:0]  ledg;
    logic [4:0]  ctl;
    int          checks = 0;
    int          errors = 0;
    logic        found, seen;

    if_alu_seq_if bus();

    if_alu_seq #(.WIDTH(8), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_n), .sw_i(sw),
        .alu(bus), .ledr_o(ledr), .ledg_o(ledg)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.alu_x, bus.alu_y, bus.alu_z, bus.alu_u, bus.alu_v};

    // ALU model: arithmetic ops are a + op2 + cin, so SUB carry means "no borrow".
    logic [7:0] a8, b8, op2, r8;
    logic [8:0] sum;
    logic       cin, ar;
    always_comb begin
        a8  = bus.alu_a[7:0];
        b8  = bus.alu_b[7:0];
        op2 = 8'h00;
        cin = 1'b0;
        ar  = 1'b1;
        r8  = 8'h00;
        case (ctl)
            5'b01001: op2 = b8;
            5'b01011: op2 = 8'h01;
            5'b11011: begin op2 = ~b8; cin = 1'b1; end
            5'b11001: op2 = 8'hFF;
            5'b00000: begin ar = 1'b0; r8 = a8 & b8; end
            5'b00100: begin ar = 1'b0; r8 = a8 | b8; end
            5'b00001: begin ar = 1'b0; r8 = a8 ^ b8; end
            5'b10001: begin ar = 1'b0; r8 = ~b8; end
            default:  ar = 1'b0;
        endcase
        sum = {1'b0, a8} + {1'b0, op2} + 9'(cin);
        if (ar) r8 = sum[7:0];
        bus.alu_result   = {8'h5A, r8};
        bus.alu_carry    = ar & sum[8];
        bus.alu_overflow = ar & (a8[7] == op2[7]) & (r8[7] != a8[7]);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        key_n = key_n & ~m;
        cyc(hold);
        key_n = key_n | m;
        cyc(12);
    endtask

    initial begin
        key_n = 3'b111;
        sw    = '1;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        key_n[0] = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(ledr[17:16]), 0);
        chk("rst_ledg", 32'(ledg), 0);
        chk("rst_ctl", 32'(ctl), 32'b01001);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_alu_b", 32'(bus.alu_b), 0);
        chk("rst_als", 32'(bus.alu_als), 0);
        key_n[0] = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(12);
        chk("post_rst_state", 32'(ledr[17:16]), 0);

        sw[7:0] = ~8'h35;
        cyc(1);
        chk("opval_disp", 32'(ledr[15:0]), 32'h35);
        press(3'b001, 12);
        chk("ldA_state", 32'(ledr[17:16]), 1);
        sw[7:0] = ~8'h0F;
        press(3'b001, 12);
        chk("ldB_state", 32'(ledr[17:16]), 2);
        chk("rdy_disp", 32'(ledr[15:0]), 32'h0F);
        key_n[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            found = ledg[7];
        end
        chk("exec_seen", 32'(found), 1);
        chk("exec_cycle_res", 32'(ledr[15:0]), 0);
        chk("exec_cycle_vld", 32'(ledg[6]), 0);
        cyc(1);
        chk("add_res", 32'(ledr[15:0]), 32'h44);
        chk("add_ledg", 32'(ledg), 32'h40);
        chk("add_state", 32'(ledr[17:16]), 3);
        chk("add_alu_a", 32'(bus.alu_a), 32'h35);
        key_n[2] = 1'b1;
        cyc(12);

        sw[7:0] = ~8'h05;
        press(3'b001, 12);
        chk("reload_state", 32'(ledr[17:16]), 1);
        chk("reload_vld", 32'(ledg[6]), 0);
        sw[7:0] = ~8'h07;
        press(3'b001, 12);
        press(3'b010, 12);
        press(3'b010, 12);
        chk("sub_op", 32'(ledg[2:0]), 2);
        chk("sub_ctl", 32'(ctl), 32'b11011);
        press(3'b100, 12);
        chk("sub_res", 32'(ledr[15:0]), 32'hFE);
        chk("sub_ledg", 32'(ledg), 32'h42);
        repeat (8) press(3'b010, 12);
        chk("wrap_op", 32'(ledg[2:0]), 2);
        chk("wrap_res", 32'(ledr[15:0]), 32'hFE);

        sw[7:0] = ~8'hFF;
        press(3'b001, 12);
        sw[7:0] = ~8'h0F;
        press(3'b001, 12);
        repeat (5) press(3'b010, 12);
        chk("not_op", 32'(ledg[2:0]), 7);
        chk("not_ctl", 32'(ctl), 32'b10001);
        chk("not_alu_a", 32'(bus.alu_a), 0);
        chk("not_alu_b", 32'(bus.alu_b), 32'h0F);
        press(3'b100, 12);
        chk("not_res", 32'(ledr[15:0]), 32'hF0);
        chk("not_ledg", 32'(ledg), 32'h47);

        sw[7:0] = ~8'hF0;
        press(3'b001, 12);
        sw[7:0] = ~8'h0F;
        press(3'b001, 12);
        repeat (5) press(3'b010, 12);
        chk("and_op", 32'(ledg[2:0]), 4);
        press(3'b100, 12);
        chk("and_res", 32'(ledr[15:0]), 0);
        chk("and_ledg", 32'(ledg), 32'h64);

        repeat (5) begin
            key_n[0] = 1'b0;
            cyc(3);
            key_n[0] = 1'b1;
            cyc(3);
        end
        cyc(12);
        chk("bounce_state", 32'(ledr[17:16]), 3);
        chk("bounce_vld", 32'(ledg[6]), 1);
        sw[7:0] = ~8'h01;
        press(3'b001, 20);
        chk("hold_state", 32'(ledr[17:16]), 1);
        press(3'b001, 12);
        chk("both_pre_state", 32'(ledr[17:16]), 2);
        key_n = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) key_n = 3'b111;
            cyc(1);
            seen = seen | ledg[7];
        end
        chk("both_state", 32'(ledr[17:16]), 1);
        chk("both_noexec", 32'(seen), 0);

        press(3'b001, 12);
        repeat (4) press(3'b010, 12);
        chk("chain_op", 32'(ledg[2:0]), 0);
        press(3'b100, 12);
        chk("chain1", 32'(ledr[15:0]), 32'h02);
        press(3'b100, 12);
`ifdef IF_ALU_SEQ_CHAIN_EN
        chk("chain2", 32'(ledr[15:0]), 32'h03);
`else
        chk("chain2", 32'(ledr[15:0]), 32'h02);
`endif
        press(3'b100, 12);
`ifdef IF_ALU_SEQ_CHAIN_EN
        chk("chain3", 32'(ledr[15:0]), 32'h04);
`else
        chk("chain3", 32'(ledr[15:0]), 32'h02);
`endif

        key_n[0] = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        chk("held_rst_state", 32'(ledr[17:16]), 0);
        key_n[0] = 1'b1;
        cyc(12);
        chk("held_rel_state", 32'(ledr[17:16]), 0);
        press(3'b001, 12);
        chk("held_repress_state", 32'(ledr[17:16]), 1);
        sw[17] = 1'b0;
        #1;
        chk("als_on", 32'(bus.alu_als), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
